// File: rtl/reg_bank_arbiter.sv
// Two-requester round-robin write arbiter in front of a small register bank.
// One write per grant; grants alternate under contention, bank is read combinationally.
module reg_bank_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREG   = 4,
  localparam int unsigned AddrW = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [AddrW-1:0]  addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  input  logic              req1,
  input  logic [AddrW-1:0]  addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  input  logic [AddrW-1:0]  raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [7:0]        wr_count
);

  typedef enum logic [0:0] {StIdle, StWrite} state_e;

  state_e              state_q, state_d;
  logic                gnt0_q, gnt0_d;
  logic                gnt1_q, gnt1_d;
  logic                busy_q, busy_d;
  logic                last_q, last_d;
  logic [AddrW-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   regs_q [NREG];
  logic [DATA_W-1:0]   regs_d [NREG];
  logic                winner;

  // Under contention the requester that did not win last time goes next.
  assign winner = (req0 && req1) ? ~last_q : req1;

  always_comb begin
    state_d = state_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    busy_d  = 1'b0;
    last_d  = last_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    regs_d  = regs_q;
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          state_d = StWrite;
          last_d  = winner;
          addr_d  = winner ? addr1 : addr0;
          data_d  = winner ? wdata1 : wdata0;
          gnt0_d  = ~winner;
          gnt1_d  = winner;
          busy_d  = 1'b1;
        end
      end
      StWrite: begin
        if (int'(addr_q) < int'(NREG)) begin
          regs_d[addr_q] = data_q;
        end
        cnt_d   = cnt_q + 8'd1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      busy_q  <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign busy     = busy_q;
  assign wr_count = cnt_q;
  assign rdata    = (int'(raddr) < int'(NREG)) ? regs_q[raddr] : '0;

endmodule

// File: doc/reg_bank_arbiter.md
# reg_bank_arbiter

Round-robin write arbiter and storage for a bank of four 16-bit enable-gated registers, shared between two requesters. Each requester presents an address and data with a request; the arbiter grants one writer at a time, performs the enabled load into the selected register, and exposes all registers through a combinational read port. It sits between producer logic and the 16-bit register storage, replacing ad-hoc `en` driving with a single sequenced write path.

## Interface
- `DATA_W`, default 16: register and write-data width.
- `NREG`, default 4: number of registers in the bank (address width 2).

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0`  in  1  requester 0 write request; held until `gnt0` seen.
- `addr0`  in  2  requester 0 target register; stable while `req0` high.
- `wdata0`  in  DATA_W  requester 0 write data; stable while `req0` high.
- `gnt0`  out  1  one-cycle grant pulse to requester 0.
- `req1`, `addr1`, `wdata1`, `gnt1`: same as above for requester 1.
- `raddr`  in  2  read address.
- `rdata`  out  DATA_W  combinational `reg[raddr]`.
- `busy`  out  1  high while the FSM is in WRITE.
- `wr_count`  out  8  number of completed writes, mod 256.

## Operation
- Storage: `reg[0..3]`, each DATA_W bits, loaded only by the arbiter's internal enable.
- FSM states: IDLE, WRITE.
  - IDLE: if neither req high, stay. Otherwise select a winner, latch its addr/data into `addr_q`/`data_q`, record winner in `last`, go to WRITE.
  - WRITE: `gnt<winner>`=1, `busy`=1; at the end of the cycle `reg[addr_q] <= data_q`, `wr_count` increments, go to IDLE. Unconditional, one cycle.
- Arbitration (in IDLE only):
  - Only req0 → 0; only req1 → 1.
  - Both → the requester not equal to `last`.
  - `last` resets to 1, so requester 0 wins the first contention.
- Handshake: a requester drops `req` on the edge where it samples `gnt` high. If `req` is still high in the following IDLE cycle, it is a new request and is arbitrated normally.
- Requests arriving during WRITE are not lost. They are evaluated in the next IDLE cycle.
- Addr/data are captured in IDLE. Changes to them during WRITE have no effect.
- Writes to the same address from back-to-back grants apply in grant order; the last one wins.
- `rdata` is purely combinational. A read of the address being written returns the old value during WRITE and the new value after the WRITE edge.
- `wr_count` wraps 255 → 0 with no flag.

## Timing
- Reset values:
  - state=IDLE; `gnt0`=`gnt1`=0; `busy`=0.
  - all `reg`=0, so `rdata`=0.
  - `wr_count`=0; `last`=1; `addr_q`=`data_q`=0.
- `rst` takes priority over every other input on any edge. Reset during WRITE aborts the write: the target register stays 0 and `wr_count` does not increment.
- Latency: with req high before edge t0 in IDLE:
  - edge t0: enter WRITE, gnt high.
  - edge t1: register updated, gnt low, back in IDLE.
  - `rdata` shows the new value from t1.
- Throughput: at most one write per 2 cycles. With both requesters continuously requesting, grants alternate 0,1,0,1 with one idle cycle between each.
- `gnt0` and `gnt1` are never high together. Each grant is exactly one cycle wide and coincides with `busy`.

## Test plan
- Reset then single write:
  - Stimulus: rst 1 cycle; req0=1, addr0=2, wdata0=15 held until gnt0.
  - Response: gnt0 high exactly 1 cycle, one edge after req. `reg[2]`=15 the edge after gnt; `rdata`(raddr=2)=15; `wr_count`=1; other regs 0.
- Contention fairness:
  - Stimulus: req0 and req1 both held high. Requester 0: addr 0, data 50. Requester 1: addr 1, data 400. Each requester re-raises its req right after its grant, for 4 grants total.
  - Response: grant order 0,1,0,1, with an IDLE cycle between grants. `reg[0]`=50, `reg[1]`=400, `wr_count`=4.
- Same-address ordering:
  - Stimulus: req0 writes 35 and req1 writes 77, both to addr 3, simultaneous, fresh after reset.
  - Response: 35 is written first, then 77. Final `reg[3]`=77.
- Reset mid-write:
  - Stimulus: req1, addr 0, data 0xABCD; assert rst in the WRITE cycle.
  - Response: `reg[0]`=0, `wr_count`=0, `gnt1` low after the reset edge, `last`=1.
- Data change during WRITE:
  - Stimulus: req0 with addr 1, data 0x1111; in the gnt cycle, change to addr 2, data 0x2222.
  - Response: `reg[1]`=0x1111 and `reg[2]`=0.
- Counter wrap:
  - Stimulus: 256 consecutive single-requester writes.
  - Response: `wr_count` reads 255 after write 255 and returns to 0 after write 256.
